// File: rtl/redop_seq_ctrl.sv
// Multi-cycle reduction sequencer: folds a DATA_W operand CHUNK_W bits per cycle (&,|,~&,~|,^,~^).
// Optional build macro REDOP_EARLY_EXIT_EN lets AND/OR-class ops leave RUN as soon as the result is decided.
module redop_seq_ctrl #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_y,
  output logic              out_err,
  output logic              busy
);

  localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid is never withdrawn and the payload never changes until that transfer.
  state_t             state, state_n;
  logic [PAD_W-1:0]   data_r, pad_data;
  logic [2:0]         op_r;
  logic               acc, err_r;
  logic [CNT_W-1:0]   cnt;

  logic               accept, fold_en;
  logic               in_ident, in_legal;
  logic               is_and, is_or, inv;
  logic [CHUNK_W-1:0] chunk;
  logic               fold_val, last;

  assign in_ident = (in_op == 3'd0) || (in_op == 3'd2);
  assign in_legal = (in_op <= 3'd5);
  assign is_and   = (op_r == 3'd0) || (op_r == 3'd2);
  assign is_or    = (op_r == 3'd1) || (op_r == 3'd3);
  assign inv      = (op_r == 3'd2) || (op_r == 3'd3) || (op_r == 3'd5);
  assign chunk    = data_r[CHUNK_W-1:0];
  assign last     = (cnt == CNT_W'(NCHUNK));

  // Pad the top partial chunk with the op's identity bit so it cannot affect the result.
  always_comb begin
    pad_data = {PAD_W{in_ident}};
    pad_data[DATA_W-1:0] = in_data;
  end

  always_comb begin
    fold_val = acc ^ (^chunk);
    if (is_and)     fold_val = acc & (&chunk);
    else if (is_or) fold_val = acc | (|chunk);
  end

`ifdef REDOP_EARLY_EXIT_EN
  logic early;
  assign early = (is_and && !acc) || (is_or && acc);
`endif

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    fold_en = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        // An illegal op spends one cycle here so its result appears one edge after acceptance.
        if (err_r || last) state_n = DONE;
`ifdef REDOP_EARLY_EXIT_EN
        else if (early)    state_n = DONE;
`endif
        else               fold_en = 1'b1;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_r <= '0;
      op_r   <= 3'd0;
      acc    <= 1'b0;
      err_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        data_r <= pad_data;
        op_r   <= in_op;
        acc    <= in_ident;
        err_r  <= !in_legal;
        cnt    <= '0;
      end else if (fold_en) begin
        data_r <= data_r >> CHUNK_W;
        acc    <= fold_val;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_err   = out_valid && err_r;
  assign out_y     = out_valid && !err_r && (acc ^ inv);

endmodule
